// File: rtl/airi5c_sim_console_pkg.sv
// Shared constants and types for the AIRI5C simulation console: register
// stride, exit-register offset, pass value and the HTRANS encodings.
package airi5c_sim_console_pkg;

  localparam int unsigned CH_STRIDE = 4;
  localparam logic [31:0] PASS_VALUE = 32'd1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_CON  = 2'd1,
    TGT_EXIT = 2'd2
  } tgt_e;

  typedef struct packed {
    logic [3:0] ch;
    logic [7:0] data;
  } con_entry_t;

  // Byte offset of the exit register: it sits right after the last channel.
  function automatic logic [31:0] exit_offset(input int unsigned num_ch);
    return 32'(num_ch * CH_STRIDE);
  endfunction

endpackage

// File: rtl/airi5c_sync_fifo.sv
// Synchronous FIFO with fall-through head; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module airi5c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/airi5c_sim_console.sv
// Passive HASTI snooper: console channel bytes into a FIFO/stream, exit
// register status and cycle counter. Watchdog enabled by AIRI5C_SIM_CONSOLE_WDT_EN.
module airi5c_sim_console
  import airi5c_sim_console_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0200,
  parameter int          NUM_CH     = 2,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] WDT_CYCLES = 32'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] haddr_i,
  input  logic [1:0]  htrans_i,
  input  logic        hwrite_i,
  input  logic        hready_i,
  input  logic [31:0] hwdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [7:0]  char_o,
  output logic [3:0]  ch_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [30:0] exit_code_o,
  output logic        overflow_o,
  output logic [15:0] drop_cnt_o,
  output logic        timeout_o,
  output logic [31:0] cycles_o
);

  localparam logic [31:0] EXIT_WORD = exit_offset(NUM_CH) / CH_STRIDE;

  logic [31:0] off_word;
  logic        con_hit;
  logic        exit_hit;
  logic        addr_ok;
  tgt_e        tgt_q;
  logic [3:0]  ch_q;

  // Word index relative to the window; addresses below BASE wrap to huge values.
  assign off_word = (haddr_i - BASE_ADDR) >> 2;
  assign con_hit  = (off_word < 32'(NUM_CH));
  assign exit_hit = (off_word == EXIT_WORD);
  assign addr_ok  = hready_i && hwrite_i &&
                    ((htrans_i == HTRANS_NONSEQ) || (htrans_i == HTRANS_SEQ));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tgt_q <= TGT_NONE;
      ch_q  <= '0;
    end else if (hready_i) begin
      if (addr_ok && con_hit)       tgt_q <= TGT_CON;
      else if (addr_ok && exit_hit) tgt_q <= TGT_EXIT;
      else                          tgt_q <= TGT_NONE;
      ch_q <= off_word[3:0];
    end
  end

  logic       dp_con;
  logic       dp_exit;
  logic       pop;
  logic       push;
  logic       drop;
  logic       fifo_full;
  logic       fifo_empty;
  con_entry_t wr_entry;
  con_entry_t head;

  assign dp_con   = hready_i && (tgt_q == TGT_CON);
  assign dp_exit  = hready_i && (tgt_q == TGT_EXIT);
  assign pop      = valid_o && ready_i;
  assign push     = dp_con && (!fifo_full || pop);
  assign drop     = dp_con && fifo_full && !pop;
  assign wr_entry = '{ch: ch_q, data: hwdata_i[7:0]};

  airi5c_sync_fifo #(
    .WIDTH ($bits(con_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (wr_entry),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign valid_o = !fifo_empty;
  assign char_o  = head.data;
  assign ch_o    = head.ch;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      overflow_o  <= 1'b0;
      drop_cnt_o  <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      exit_code_o <= '0;
      cycles_o    <= '0;
    end else begin
      if (drop) begin
        overflow_o <= 1'b1;
        if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
      end
      // A zero exit value is treated as "no exit" and only the first exit counts.
      if (dp_exit && (hwdata_i != 32'd0) && !done_o) begin
        done_o      <= 1'b1;
        pass_o      <= (hwdata_i == PASS_VALUE);
        exit_code_o <= hwdata_i[31:1];
      end
      if (!done_o && (cycles_o != '1)) cycles_o <= cycles_o + 32'd1;
    end
  end

`ifdef AIRI5C_SIM_CONSOLE_WDT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timeout_o <= 1'b0;
    end else if (!done_o && (cycles_o == WDT_CYCLES - 32'd1)) begin
      timeout_o <= 1'b1;
    end
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_airi5c_sim_console.sv
// Self-checking bench for airi5c_sim_console: transaction-level queue model
// of the console FIFO, exit register, cycle counter and watchdog.
module tb_airi5c_sim_console;
  import airi5c_sim_console_pkg::*;

  localparam logic [31:0] BASE   = 32'hC000_0200;
  localparam int          NUM_CH = 2;
  localparam int          DEPTH  = 16;
  localparam logic [31:0] WDT    = 32'd100;
  localparam logic [31:0] EXIT_A = BASE + 32'(4 * NUM_CH);

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] haddr_i;
  logic [1:0]  htrans_i;
  logic        hwrite_i;
  logic        hready_i;
  logic [31:0] hwdata_i;
  logic        valid_o;
  logic        ready_i;
  logic [7:0]  char_o;
  logic [3:0]  ch_o;
  logic        done_o;
  logic        pass_o;
  logic [30:0] exit_code_o;
  logic        overflow_o;
  logic [15:0] drop_cnt_o;
  logic        timeout_o;
  logic [31:0] cycles_o;

  airi5c_sim_console #(
    .BASE_ADDR  (BASE),
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (DEPTH),
    .WDT_CYCLES (WDT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .haddr_i     (haddr_i),
    .htrans_i    (htrans_i),
    .hwrite_i    (hwrite_i),
    .hready_i    (hready_i),
    .hwdata_i    (hwdata_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .char_o      (char_o),
    .ch_o        (ch_o),
    .done_o      (done_o),
    .pass_o      (pass_o),
    .exit_code_o (exit_code_o),
    .overflow_o  (overflow_o),
    .drop_cnt_o  (drop_cnt_o),
    .timeout_o   (timeout_o),
    .cycles_o    (cycles_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- scoreboard / model ----------------
  int n_chk  = 0;
  int n_fail = 0;

  logic [11:0] exp_q[$];
  logic        pend_m, pend_ex_m;
  logic [3:0]  pend_ch_m;
  logic        done_m, pass_m, ovf_m, to_m;
  logic [30:0] code_m;
  logic [15:0] drop_m;
  logic [31:0] cyc_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void decode(input logic [31:0] a, output logic hit,
                                 output logic ex, output logic [3:0] c);
    hit = 1'b0;
    ex  = 1'b0;
    c   = 4'd0;
    for (int i = 0; i < NUM_CH; i++)
      if ((a & ~32'd3) == BASE + 32'(4 * i)) begin
        hit = 1'b1;
        c   = 4'(i);
      end
    if ((a & ~32'd3) == EXIT_A) begin
      hit = 1'b1;
      ex  = 1'b1;
    end
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend_m = 1'b0; pend_ex_m = 1'b0; pend_ch_m = 4'd0;
    done_m = 1'b0; pass_m = 1'b0; ovf_m = 1'b0; to_m = 1'b0;
    code_m = '0; drop_m = '0; cyc_m = '0;
  endtask

  // One clock edge of the reference model, from the inputs the bench drives.
  task automatic model_step();
    logic pop, full, hit, ex, done_old;
    logic [3:0] c;
    done_old = done_m;
    pop  = ready_i && (exp_q.size() > 0);
    full = (exp_q.size() == DEPTH);
    if (pop) void'(exp_q.pop_front());
    if (pend_m && hready_i) begin
      if (pend_ex_m) begin
        if (hwdata_i != 32'd0 && !done_m) begin
          done_m = 1'b1;
          pass_m = (hwdata_i == 32'd1);
          code_m = hwdata_i[31:1];
        end
      end else if (!full || pop) begin
        exp_q.push_back({pend_ch_m, hwdata_i[7:0]});
      end else begin
        ovf_m = 1'b1;
        if (drop_m != 16'hFFFF) drop_m = drop_m + 16'd1;
      end
    end
`ifdef AIRI5C_SIM_CONSOLE_WDT_EN
    if (!done_old && cyc_m == WDT - 32'd1) to_m = 1'b1;
`endif
    if (!done_old && cyc_m != 32'hFFFF_FFFF) cyc_m = cyc_m + 32'd1;
    if (hready_i) begin
      decode(haddr_i, hit, ex, c);
      pend_m    = htrans_i[1] && hwrite_i && hit;
      pend_ex_m = ex;
      pend_ch_m = c;
    end
  endtask

  task automatic check_all();
    logic [11:0] h;
    chk("valid", 32'(valid_o), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      chk("char", 32'(char_o), 32'(h[7:0]));
      chk("ch", 32'(ch_o), 32'(h[11:8]));
    end
    chk("done", 32'(done_o), 32'(done_m));
    chk("pass", 32'(pass_o), 32'(pass_m));
    chk("exit_code", 32'(exit_code_o), 32'(code_m));
    chk("overflow", 32'(overflow_o), 32'(ovf_m));
    chk("drop_cnt", 32'(drop_cnt_o), 32'(drop_m));
    chk("timeout", 32'(timeout_o), 32'(to_m));
    chk("cycles", cycles_o, cyc_m);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_all();
  endtask

  task automatic bus_idle();
    haddr_i  = 32'h0;
    htrans_i = HTRANS_IDLE;
    hwrite_i = 1'b0;
    hready_i = 1'b1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_pass", 32'(pass_o), 32'd0);
    chk("rst_code", 32'(exit_code_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);
    chk("rst_cycles", cycles_o, 32'd0);
    @(negedge clk_i);
    bus_idle();
    ready_i = 1'b0;
    rst_ni  = 1'b1;
  endtask

  logic [31:0] wr_addr  [64];
  logic [31:0] wr_data  [64];
  logic [1:0]  wr_trans [64];
  logic        wr_write [64];
  int          wr_n;

  task automatic add(input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] t, input logic w);
    wr_addr[wr_n] = a; wr_data[wr_n] = d; wr_trans[wr_n] = t; wr_write[wr_n] = w;
    wr_n++;
  endtask

  // Issue wr_n pipelined transfers with random wait states and consumer stalls.
  task automatic drive_writes(input int wait_pct, input int ready_pct);
    int i = 0;
    logic have_dp = 1'b0;
    logic [31:0] dp_data = 32'h0;
    while (i < wr_n || have_dp) begin
      hready_i = ($urandom_range(0, 99) >= wait_pct);
      ready_i  = ($urandom_range(0, 99) < ready_pct);
      hwdata_i = have_dp ? dp_data : $urandom;
      if (i < wr_n) begin
        haddr_i  = wr_addr[i];
        htrans_i = wr_trans[i];
        hwrite_i = wr_write[i];
      end else begin
        haddr_i  = $urandom;
        htrans_i = HTRANS_IDLE;
        hwrite_i = 1'b0;
      end
      tick();
      if (hready_i) begin
        have_dp = (i < wr_n);
        if (i < wr_n) begin
          dp_data = wr_data[i];
          i++;
        end
      end
    end
    bus_idle();
    wr_n = 0;
  endtask

  task automatic add_random();
    int r;
    logic [31:0] con_a;
    r = $urandom_range(0, 99);
    con_a = BASE + 32'(4 * $urandom_range(0, NUM_CH - 1)) + 32'($urandom_range(0, 3));
    if (r < 60)      add(con_a, $urandom, 2'($urandom_range(2, 3)), 1'b1);
    else if (r < 70) add(BASE + 32'(4 * $urandom_range(NUM_CH + 1, NUM_CH + 8)), $urandom, HTRANS_NONSEQ, 1'b1);
    else if (r < 75) add(BASE - 32'd4, $urandom, HTRANS_NONSEQ, 1'b1);
    else if (r < 83) add(con_a, $urandom, 2'($urandom_range(0, 1)), 1'b1);
    else if (r < 93) add(con_a, $urandom, HTRANS_NONSEQ, 1'b0);
    else             add(EXIT_A, 32'($urandom_range(0, 3)), HTRANS_NONSEQ, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] c_frozen;

  initial begin
    wr_n     = 0;
    hwdata_i = 32'h0;
    ready_i  = 1'b0;
    bus_idle();
    rst_ni   = 1'b0;
    @(negedge clk_i);
    do_reset();

    // single byte, one beat
    ready_i = 1'b1;
    add(BASE, 32'h41, HTRANS_NONSEQ, 1'b1);
    drive_writes(0, 100);
    chk("single_valid", 32'(valid_o), 32'd1);
    chk("single_char", 32'(char_o), 32'h41);
    chk("single_ch", 32'(ch_o), 32'd0);
    ready_i = 1'b1;
    tick();
    chk("single_once", 32'(valid_o), 32'd0);

    // back-to-back ch0/ch1 with two wait states in the first data phase
    ready_i  = 1'b0;
    haddr_i  = BASE; htrans_i = HTRANS_NONSEQ; hwrite_i = 1'b1; hready_i = 1'b1;
    tick();
    haddr_i  = BASE + 32'd4; htrans_i = HTRANS_SEQ; hwdata_i = 32'h61; hready_i = 1'b0;
    tick();
    tick();
    hready_i = 1'b1;
    tick();
    bus_idle();
    hwdata_i = 32'h62;
    tick();
    chk("pipe_head0", 32'(char_o), 32'h61);
    chk("pipe_ch0", 32'(ch_o), 32'd0);
    ready_i = 1'b1;
    tick();
    chk("pipe_head1", 32'(char_o), 32'h62);
    chk("pipe_ch1", 32'(ch_o), 32'd1);
    tick();
    chk("pipe_empty", 32'(valid_o), 32'd0);

    // non-matching addresses, IDLE/BUSY and reads
    add(BASE + 32'(4 * (NUM_CH + 1)), 32'h55, HTRANS_NONSEQ, 1'b1);
    add(BASE - 32'd4, 32'h56, HTRANS_NONSEQ, 1'b1);
    add(BASE, 32'h57, HTRANS_IDLE, 1'b1);
    add(BASE + 32'd4, 32'h58, HTRANS_BUSY, 1'b1);
    add(BASE, 32'h59, HTRANS_NONSEQ, 1'b0);
    drive_writes(30, 100);
    tick();
    chk("nomatch_valid", 32'(valid_o), 32'd0);
    chk("nomatch_done", 32'(done_o), 32'd0);

    // overflow: 18 writes into a stalled 16-entry FIFO
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) add(BASE, 32'(8'h30 + i), HTRANS_NONSEQ, 1'b1);
    drive_writes(0, 0);
    chk("ovf_flag", 32'(overflow_o), 32'd1);
    chk("ovf_drop", 32'(drop_cnt_o), 32'd2);
    chk("ovf_head", 32'(char_o), 32'h30);

    // full FIFO with a pop in the data-phase cycle
    ready_i  = 1'b0;
    haddr_i  = BASE + 32'd4; htrans_i = HTRANS_NONSEQ; hwrite_i = 1'b1;
    tick();
    bus_idle();
    hwdata_i = 32'hAA;
    ready_i  = 1'b1;
    tick();
    ready_i  = 1'b0;
    chk("fullpop_drop", 32'(drop_cnt_o), 32'd2);
    ready_i = 1'b1;
    repeat (DEPTH + 2) tick();
    chk("drain_empty", 32'(valid_o), 32'd0);

    // exit register
    do_reset();
    add(EXIT_A, 32'd0, HTRANS_NONSEQ, 1'b1);
    drive_writes(0, 100);
    tick();
    chk("exit0_ignored", 32'(done_o), 32'd0);
    add(EXIT_A, 32'd1, HTRANS_NONSEQ, 1'b1);
    drive_writes(0, 100);
    chk("exit1_done", 32'(done_o), 32'd1);
    chk("exit1_pass", 32'(pass_o), 32'd1);
    c_frozen = cyc_m;
    repeat (5) tick();
    chk("cyc_frozen", cycles_o, c_frozen);
    add(EXIT_A, 32'd5, HTRANS_NONSEQ, 1'b1);
    drive_writes(0, 100);
    chk("exit2_pass", 32'(pass_o), 32'd1);
    chk("exit2_code", 32'(exit_code_o), 32'd0);
    do_reset();
    add(EXIT_A, 32'd7, HTRANS_NONSEQ, 1'b1);
    drive_writes(0, 100);
    chk("exit7_done", 32'(done_o), 32'd1);
    chk("exit7_pass", 32'(pass_o), 32'd0);
    chk("exit7_code", 32'(exit_code_o), 32'd3);

    // watchdog
    do_reset();
    repeat (int'(WDT) - 1) tick();
    chk("wdt_early", 32'(timeout_o), 32'd0);
    tick();
    chk("wdt_cycles", cycles_o, WDT);
`ifdef AIRI5C_SIM_CONSOLE_WDT_EN
    chk("wdt_fire", 32'(timeout_o), 32'd1);
`else
    chk("wdt_fire", 32'(timeout_o), 32'd0);
`endif
    add(EXIT_A, 32'd1, HTRANS_NONSEQ, 1'b1);
    drive_writes(0, 100);
    chk("wdt_exit_done", 32'(done_o), 32'd1);

    // randomized traffic, with a reset in the middle of a stalled stream
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 30; k++) add_random();
      drive_writes($urandom_range(0, 50), (it == 4) ? 0 : $urandom_range(20, 100));
      if (it == 4) begin
        do_reset();
        tick();
        chk("midrst_valid", 32'(valid_o), 32'd0);
      end else begin
        ready_i = 1'b1;
        repeat (DEPTH + 2) tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
